arb_mux_n: RTL and testbench
============================

ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 Parameter n_bit, default 32, data width per channel in bits.
REQ-002 Parameter n_ch, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter sel_w, default $clog2(n_ch), channel-index width; derived, not overridden.
REQ-004 in_clk  input  1  single clock; all state updates on rising edge.
REQ-005 in_reset  input  1  synchronous, active-high reset.
REQ-006 in_mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-007 in_valid  input  n_ch  per-channel request; bit i qualifies channel i.
REQ-008 in_data  input  n_ch*n_bit  packed channel data; channel i at [i*n_bit +: n_bit].
REQ-009 out_ch_ready  output  n_ch  per-channel accept strobe, at most one bit high; combinational.
REQ-010 out_valid  output  1  output register holds a valid word.
REQ-011 out_data  output  n_bit  registered selected data.
REQ-012 out_channel  output  sel_w  index of the channel that supplied out_data.
REQ-013 in_dst_ready  input  1  downstream accepts out_data when out_valid && in_dst_ready.

Function
REQ-014 load = !out_valid || in_dst_ready; no channel is accepted when load is 0.
REQ-015 Winner g: mode 0 = first i with in_valid[i] scanning ptr, ptr+1, ..., wrapping n_ch-1 -> 0; mode 1 = lowest i with in_valid[i].
REQ-016 out_ch_ready[g] = load && |in_valid; all other bits 0.
REQ-017 On accept: out_data <= in_data[g], out_channel <= g, out_valid <= 1 at the next edge; latency one cycle.
REQ-018 load && in_valid == 0: out_valid <= 0; out_data and out_channel hold.
REQ-019 !load: out_valid, out_data, out_channel hold (output stable while stalled).
REQ-020 Round-robin pointer ptr (sel_w bits) <= (g == n_ch-1) ? 0 : g+1 on every accept, in both modes.
REQ-021 ptr unchanged when no accept occurs.
REQ-022 A channel deasserting in_valid while not accepted is legal; no state retained for it.
REQ-023 in_mode switching takes effect the same cycle; no flush.
REQ-024 Full throughput: with in_dst_ready held 1 and a requester present, one word accepted per cycle.
REQ-025 Fairness in mode 0: a continuously requesting channel is accepted within n_ch accepts.

Reset
REQ-026 While in_reset = 1 at an edge: out_valid <= 0, out_data <= 0, out_channel <= 0, ptr <= 0.
REQ-027 out_ch_ready forced to 0 while in_reset = 1.
REQ-028 Reset mid-stall discards the held word; no transfer reported for it.
REQ-029 First cycle after reset release: normal arbitration from ptr = 0.

Structure
REQ-030 Shared package mux_pkg holds default n_bit (32), default n_ch (4), mode encodings MODE_RR = 0 and MODE_FIXED = 1.
REQ-031 One combinational sub-module rr_picker (inputs: request vector, ptr, mode; outputs: grant index, any-grant) performs REQ-015.
REQ-032 All sequential state (output register, ptr) lives in arb_mux_n; no latches.

Verification
REQ-033 Reset: in_reset = 1 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_ch_ready = 0; after release ch0 is accepted first.
REQ-034 Round-robin: n_ch = 4, mode 0, in_valid = 4'b1111, data ch i = 32'hA0+i, in_dst_ready = 1 -> out_channel 0,1,2,3,0 on consecutive cycles, out_data matching.
REQ-035 Fixed priority: mode 1, in_valid = 4'b1110 -> ch1 (32'hA1) every cycle; ch2/ch3 out_ch_ready stay 0.
REQ-036 Backpressure: out_valid = 1 with 32'hA2, in_dst_ready = 0 for 3 cycles -> out_data held at 32'hA2, out_ch_ready = 0, ptr unchanged; ready returns -> next winner loaded next cycle.
REQ-037 Wrap/sparse: ptr = 3, in_valid = 4'b0100 -> ch2 accepted, ptr becomes 3; then in_valid = 4'b1000 -> ch3 accepted, ptr wraps to 0.
REQ-038 Idle drain: one word pending, in_valid = 0, in_dst_ready = 1 -> out_valid falls to 0 next cycle, out_data holds last value.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and mode encodings for the N-channel arbitrating output mux.
package mux_pkg;
  localparam int N_BIT_DEF = 32;
  localparam int N_CH_DEF  = 4;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } arb_mode_e;
endpackage

// File: rtl/arb_mux_n_rr_picker.sv
// Combinational grant picker: rotating scan from ptr, or fixed scan from index 0.
module rr_picker
  import mux_pkg::*;
#(
  parameter int n_ch  = N_CH_DEF,
  parameter int sel_w = $clog2(n_ch)
) (
  input  logic [n_ch-1:0]  req,
  input  logic [sel_w-1:0] ptr,
  input  logic             mode,
  output logic [sel_w-1:0] grant,
  output logic             any
);
  logic [sel_w-1:0] base;
  logic [sel_w-1:0] idx;
  logic             found;

  assign base = (mode == MODE_FIXED) ? '0 : ptr;
  assign any  = |req;

  // ptr is always < n_ch, so a wrap test replaces a modulo for non-power-of-2 n_ch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = base;
    for (int k = 0; k < n_ch; k++) begin
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
      idx = (idx == sel_w'(n_ch - 1)) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating mux with a single registered output stage and backpressure.
module arb_mux_n
  import mux_pkg::*;
#(
  parameter  int n_bit = N_BIT_DEF,
  parameter  int n_ch  = N_CH_DEF,
  localparam int sel_w = $clog2(n_ch)
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_mode,
  input  logic [n_ch-1:0]       in_valid,
  input  logic [n_ch*n_bit-1:0] in_data,
  output logic [n_ch-1:0]       out_ch_ready,
  output logic                  out_valid,
  output logic [n_bit-1:0]      out_data,
  output logic [sel_w-1:0]      out_channel,
  input  logic                  in_dst_ready
);
  logic [n_ch-1:0][n_bit-1:0] data_arr;
  logic [sel_w-1:0]           ptr;
  logic [sel_w-1:0]           grant;
  logic                       any;
  logic                       load;
  logic                       accept;

  assign data_arr = in_data;
  assign load     = !out_valid || in_dst_ready;
  assign accept   = load && any && !in_reset;

  rr_picker #(.n_ch(n_ch), .sel_w(sel_w)) u_picker (
    .req   (in_valid),
    .ptr   (ptr),
    .mode  (in_mode),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    out_ch_ready = '0;
    if (accept) out_ch_ready[grant] = 1'b1;
  end

  // Pointer advances past the winner in both modes so a later switch to RR stays fair.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      ptr         <= '0;
    end else if (load) begin
      if (any) begin
        out_valid   <= 1'b1;
        out_data    <= data_arr[grant];
        out_channel <= grant;
        ptr         <= (grant == sel_w'(n_ch - 1)) ? '0 : grant + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_arb_mux_n.sv
// Directed plus random check of arb_mux_n against a small scoreboard model.
module tb_arb_mux_n;
  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [3:0]        valid;
  logic [3:0][31:0]  din;
  logic [127:0]      in_data;
  logic [3:0]        out_ch_ready;
  logic              out_valid;
  logic [31:0]       out_data;
  logic [1:0]        out_channel;
  logic              dst_ready;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  c;
  } exp_t;

  exp_t        q[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [1:0]  m_ch    = '0;
  logic [1:0]  m_ptr   = '0;
  int          checks  = 0;
  int          errors  = 0;

  assign in_data = din;

  always #5 clk = ~clk;

  arb_mux_n #(.n_bit(32), .n_ch(4)) dut (
    .in_clk       (clk),
    .in_reset     (rst),
    .in_mode      (mode),
    .in_valid     (valid),
    .in_data      (in_data),
    .out_ch_ready (out_ch_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_channel  (out_channel),
    .in_dst_ready (dst_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input logic [1:0] p, input logic md);
    logic [1:0] base;
    logic [1:0] ii;
    base = md ? 2'd0 : p;
    for (int k = 0; k < 4; k++) begin
      ii = base + 2'(k);
      if (v[ii]) return int'(ii);
    end
    return -1;
  endfunction

  // Inputs are set just after a falling edge; ready is checked before the rising edge,
  // registered outputs just after it.
  task automatic cycle();
    logic       load;
    int         w;
    logic [1:0] wi;
    logic [3:0] er;
    exp_t       e;
    #1;
    load = !m_valid || dst_ready;
    w    = pick(valid, m_ptr, mode);
    er   = '0;
    if (!rst && load && w >= 0) begin
      wi     = w[1:0];
      er[wi] = 1'b1;
      e.d    = din[wi];
      e.c    = wi;
      q.push_back(e);
    end
    chk("ch_ready", 32'(out_ch_ready), 32'(er));
    @(posedge clk); #1;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = '0;
      q.delete();
    end else if (load) begin
      if (q.size() > 0) begin
        e       = q.pop_front();
        m_valid = 1'b1;
        m_data  = e.d;
        m_ch    = e.c;
        m_ptr   = e.c + 2'd1;
      end else begin
        m_valid = 1'b0;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_channel", 32'(out_channel), 32'(m_ch));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; valid = 4'b1111; dst_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 32'hA0 + 32'(i);
    @(negedge clk);

    // Reset with all channels requesting
    cycle();
    cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);

    // Round-robin 0,1,2,3,0
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_seq_ch", 32'(out_channel), 32'(i % 4));
      chk("rr_seq_data", out_data, 32'hA0 + 32'(i % 4));
    end

    // Fixed priority, ch0 idle
    mode = 1'b1; valid = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fixed_ready", 32'(out_ch_ready), 32'h2);
      cycle();
      chk("fixed_data", out_data, 32'hA1);
    end

    // Backpressure: load ch2 then stall three cycles
    mode = 1'b0; valid = 4'b1111;
    cycle();
    chk("bp_load", out_data, 32'hA2);
    dst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold", out_data, 32'hA2);
    end
    dst_ready = 1'b1;
    cycle();
    chk("bp_resume", 32'(out_channel), 32'd3);

    // Sparse and wrap: ptr 0 -> ch2 (ptr 3) -> ch2 again -> ch3 (ptr 0) -> ch0
    valid = 4'b0100;
    cycle();
    cycle();
    chk("sparse_ch2", 32'(out_channel), 32'd2);
    valid = 4'b1000;
    cycle();
    chk("wrap_ch3", 32'(out_channel), 32'd3);
    valid = 4'b1111;
    cycle();
    chk("wrap_ptr0", 32'(out_channel), 32'd0);

    // Idle drain
    valid = 4'b0000;
    cycle();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold", out_data, 32'hA0);

    // Reset while stalled discards the held word
    valid = 4'b1111;
    cycle();
    dst_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_stall_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; dst_ready = 1'b1;
    cycle();
    chk("post_rst_ch0", 32'(out_channel), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      valid     = 4'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 1));
      dst_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) din[c] = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
